// File: rtl/ram_dp_param_if.sv
// Bus bundle for ram_dp_param: one byte-enabled write port, one registered read port,
// and the init sweep status flag.
interface ram_dp_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic                  we;
   logic                  prt_en0;
   logic [ADDR_W-1:0]     address_0;
   logic [DATA_W-1:0]     data_0;
   logic [DATA_W/8-1:0]   be_0;
   logic                  re;
   logic                  prt_en1;
   logic [ADDR_W-1:0]     address_1;
   logic [DATA_W-1:0]     data_1;
   logic                  rd_valid;
   logic                  init_busy;

   modport master (
      output we, prt_en0, address_0, data_0, be_0,
      output re, prt_en1, address_1,
      input  data_1, rd_valid, init_busy
   );

   modport slave (
      input  we, prt_en0, address_0, data_0, be_0,
      input  re, prt_en1, address_1,
      output data_1, rd_valid, init_busy
   );
endinterface

// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with byte enables, zero-fill sweep after reset and 1-cycle read.
// Define RAM_DP_PARAM_BYPASS_EN for write-first same-address behaviour (default read-first).
module ram_dp_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   ram_dp_param_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   cnt_reg, cnt_next;

   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [NB-1:0]       wr_be;
   logic                rd_acc;
   logic                rd_valid_reg;
   logic [DATA_W-1:0]   rd_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_INIT;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The sweep borrows the write port; user traffic is simply dropped until RUN.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wr_en      = 1'b0;
      wr_addr    = bus.address_0;
      wr_data    = bus.data_0;
      wr_be      = bus.be_0;
      rd_acc     = 1'b0;
      case (state_reg)
         ST_INIT: begin
            wr_en    = 1'b1;
            wr_addr  = cnt_reg;
            wr_data  = '0;
            wr_be    = '1;
            cnt_next = cnt_reg + ADDR_W'(1);
            if (cnt_reg == {ADDR_W{1'b1}}) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            wr_en  = bus.we & bus.prt_en0;
            rd_acc = bus.re & bus.prt_en1;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

`ifdef RAM_DP_PARAM_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = wr_en && (wr_addr == bus.address_1);
`endif

   // One 8-bit RAM per byte lane keeps byte enables a plain per-lane write enable.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] wr_byte;
         logic [7:0] rd_byte_reg;

         assign wr_byte = wr_data[8*gi +: 8];

         always_ff @(posedge clk) begin
            if (rst_n && wr_en && wr_be[gi]) begin
               mem_lane[wr_addr] <= wr_byte;
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_byte_reg <= '0;
            end else if (rd_acc) begin
`ifdef RAM_DP_PARAM_BYPASS_EN
               rd_byte_reg <= (bypass_hit && wr_be[gi]) ? wr_byte : mem_lane[bus.address_1];
`else
               rd_byte_reg <= mem_lane[bus.address_1];
`endif
            end
         end

         assign rd_data[8*gi +: 8] = rd_byte_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_acc;
      end
   end

   assign bus.data_1    = rd_data;
   assign bus.rd_valid  = rd_valid_reg;
   assign bus.init_busy = (state_reg == ST_INIT);
endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench for ram_dp_param: stimulus pushes expected read data, a negedge
// monitor pops and compares whenever rd_valid is seen.
module tb_ram_dp_param;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   exp_t exp_q[$];

   ram_dp_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_dp_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every rd_valid cycle must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rd_valid === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rd_valid data_1=%h required=no read", bus.data_1);
         end else begin
            e = exp_q.pop_front();
            if (bus.data_1 !== e.data) begin
               n_err++;
               $display("FAIL read addr=%0d data_1=%h required=%h", e.addr, bus.data_1, e.data);
            end else begin
               $display("read addr=%0d data_1=%h ok", e.addr, bus.data_1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end else begin
         $display("check %s value=%h ok", name, act);
      end
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.prt_en0 = 1'b0; bus.re = 1'b0; bus.prt_en1 = 1'b0;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
      bus.we = 1'b1; bus.prt_en0 = 1'b1; bus.address_0 = a; bus.data_0 = d; bus.be_0 = be;
      tick();
      idle();
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_t e;
      e.addr = a; e.data = d;
      bus.re = 1'b1; bus.prt_en1 = 1'b1; bus.address_1 = a;
      exp_q.push_back(e);
      tick();
      idle();
   endtask

   task automatic do_wr_rd(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                           input logic [3:0] be, input logic [ADDR_W-1:0] ra,
                           input logic [DATA_W-1:0] rd);
      exp_t e;
      e.addr = ra; e.data = rd;
      bus.we = 1'b1; bus.prt_en0 = 1'b1; bus.address_0 = wa; bus.data_0 = wd; bus.be_0 = be;
      bus.re = 1'b1; bus.prt_en1 = 1'b1; bus.address_1 = ra;
      exp_q.push_back(e);
      tick();
      idle();
   endtask

   // Counts cycles with init_busy high; at cycle inject_at it pulses a write and read.
   task automatic measure_busy(output int cyc, input int inject_at);
      cyc = 0;
      while (bus.init_busy === 1'b1 && cyc < 100) begin
         if (cyc == inject_at) begin
            bus.we = 1'b1; bus.prt_en0 = 1'b1; bus.address_0 = 5'd5;
            bus.data_0 = 32'hFFFF_FFFF; bus.be_0 = 4'hF;
            bus.re = 1'b1; bus.prt_en1 = 1'b1; bus.address_1 = 5'd5;
         end
         tick();
         if (cyc == inject_at) begin
            check("init_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
         end
         idle();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      idle();
      bus.address_0 = '0; bus.data_0 = '0; bus.be_0 = '0; bus.address_1 = '0;
      repeat (3) tick();

      check("rst_data_1", bus.data_1, 32'd0);
      check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      check("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);

      rst_n = 1'b1;
      measure_busy(cyc, -1);
      check("sweep_cycles", 32'(cyc), 32'd32);

      for (int i = 0; i < 32; i++) do_read(5'(i), 32'd0);
      for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 1), 4'hF);
      for (int i = 0; i < 32; i++) do_read(5'(i), 32'(i + 1));
      repeat (2) tick();
      check("data_1_hold", bus.data_1, 32'd32);

      do_write(5'd3, 32'hAABB_CCDD, 4'hF);
      do_write(5'd3, 32'h1122_3344, 4'b0101);
      do_read(5'd3, 32'hAA22_CC44);
      do_write(5'd3, 32'hDEAD_BEEF, 4'b0000);
      do_read(5'd3, 32'hAA22_CC44);

      do_write(5'd7, 32'h5, 4'hF);
`ifdef RAM_DP_PARAM_BYPASS_EN
      do_wr_rd(5'd7, 32'h9, 4'hF, 5'd7, 32'h9);
`else
      do_wr_rd(5'd7, 32'h9, 4'hF, 5'd7, 32'h5);
`endif
      do_read(5'd7, 32'h9);

      do_wr_rd(5'd8, 32'h0000_1234, 4'hF, 5'd3, 32'hAA22_CC44);
      do_read(5'd8, 32'h0000_1234);
      do_read(5'd31, 32'd32);
      tick();

      // Reset with a read pending: read discarded, data_1 cleared.
      bus.re = 1'b1; bus.prt_en1 = 1'b1; bus.address_1 = 5'd3;
      rst_n = 1'b0;
      tick();
      idle();
      check("rst_inflight_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
      check("rst_inflight_data_1", bus.data_1, 32'd0);
      rst_n = 1'b1;
      repeat (10) tick();
      check("midsweep_busy", {31'd0, bus.init_busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      measure_busy(cyc, 20);
      check("resweep_cycles", 32'(cyc), 32'd32);
      tick();

      do_read(5'd5, 32'd0);
      do_read(5'd8, 32'd0);
      do_read(5'd3, 32'd0);
      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
